// File: rtl/io_ccff_chain_loader.sv
// Loads an io-tile ccff chain from a word stream, then recirculates the chain once and compares CRC-8 signatures.
// Latency: ceil(CHAIN_LEN/WORD_W) capture cycles + CHAIN_LEN load shifts + CHAIN_LEN verify shifts + 1 check cycle.
// Backpressure: cfg_ready is high only in LOAD while the word register is empty; a stalled source gates the chain clock off.
module io_ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_en,
    output logic              isol_n,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_VERIFY,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam int               BW     = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] WORD_C = CNT_W'(WORD_W);

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] word_sreg;
    logic [BW-1:0]     bits_left;
    logic [CNT_W-1:0]  bit_cnt;
    logic [7:0]        crc_in;
    logic [7:0]        crc_out;
    logic              head_q;

    logic              bit_pend;
    logic              word_take;
    logic              start_ok;
    logic [CNT_W-1:0]  remaining;
    logic [BW-1:0]     take_bits;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    assign bit_pend  = (state == S_LOAD) && (bits_left != '0);
    assign word_take = cfg_valid && cfg_ready;
    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    assign remaining = LEN_C - bit_cnt;
    // The final word only contributes the bits still missing from the chain.
    assign take_bits = (remaining >= WORD_C) ? BW'(WORD_W) : BW'(remaining);

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = S_LOAD;
            S_LOAD:   if (bit_pend && (bit_cnt == LAST_C)) state_nxt = S_VERIFY;
            S_VERIFY: if (bit_cnt == LAST_C) state_nxt = S_CHECK;
            S_CHECK:  state_nxt = (crc_out == crc_in) ? S_DONE : S_ERROR;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state == S_LOAD) && (bits_left == '0) && (bit_cnt < LEN_C);
        ccff_en   = bit_pend || (state == S_VERIFY);
        ccff_head = head_q;
        if (state == S_VERIFY) begin
            ccff_head = ccff_tail;
        end else if (bit_pend) begin
            ccff_head = word_sreg[WORD_W-1];
        end
        busy   = (state == S_LOAD) || (state == S_VERIFY) || (state == S_CHECK);
        done   = (state == S_DONE);
        error  = (state == S_ERROR);
        isol_n = (state == S_DONE);
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            word_sreg <= '0;
            bits_left <= '0;
            bit_cnt   <= '0;
            crc_in    <= '0;
            crc_out   <= '0;
            head_q    <= 1'b0;
        end else if (start_ok) begin
            word_sreg <= '0;
            bits_left <= '0;
            bit_cnt   <= '0;
            crc_in    <= '0;
            crc_out   <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (word_take) begin
                        word_sreg <= cfg_data;
                        bits_left <= take_bits;
                    end else if (bit_pend) begin
                        word_sreg <= word_sreg << 1;
                        bits_left <= bits_left - BW'(1);
                        crc_in    <= crc8_step(crc_in, word_sreg[WORD_W-1]);
                        head_q    <= word_sreg[WORD_W-1];
                        bit_cnt   <= (bit_cnt == LAST_C) ? '0 : bit_cnt + CNT_W'(1);
                    end
                end
                S_VERIFY: begin
                    // Recirculation: whatever leaves the tail re-enters at the head.
                    crc_out <= crc8_step(crc_out, ccff_tail);
                    head_q  <= ccff_tail;
                    bit_cnt <= (bit_cnt == LAST_C) ? '0 : bit_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_io_ccff_chain_loader.sv
// Bench for io_ccff_chain_loader: two instances (16-bit and 12-bit chains) each driving a behavioural shift chain.
module tb_io_ccff_chain_loader;

    logic            prog_clk = 1'b0;
    logic [1:0]      pReset_v = 2'b11;
    logic [1:0]      start_v  = 2'b00;
    logic [1:0][7:0] cfg_data_v = '0;
    logic [1:0]      cfg_valid_v = 2'b00;
    logic [1:0]      cfg_ready_v, head_v, tail_v, en_v, isol_v, busy_v, done_v, error_v;
    logic [1:0]      flip_v = 2'b00;

    logic [15:0] chain0 = '0;
    logic [11:0] chain1 = '0;

    logic [7:0] wq [4];
    int         gq [4];

    int n_checks = 0;
    int n_errors = 0;

    always #5 prog_clk = ~prog_clk;

    io_ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8), .CNT_W(16)) u_dut16 (
        .prog_clk(prog_clk), .pReset(pReset_v[0]), .start(start_v[0]),
        .cfg_data(cfg_data_v[0]), .cfg_valid(cfg_valid_v[0]), .cfg_ready(cfg_ready_v[0]),
        .ccff_head(head_v[0]), .ccff_tail(tail_v[0]), .ccff_en(en_v[0]),
        .isol_n(isol_v[0]), .busy(busy_v[0]), .done(done_v[0]), .error(error_v[0]));

    io_ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8), .CNT_W(16)) u_dut12 (
        .prog_clk(prog_clk), .pReset(pReset_v[1]), .start(start_v[1]),
        .cfg_data(cfg_data_v[1]), .cfg_valid(cfg_valid_v[1]), .cfg_ready(cfg_ready_v[1]),
        .ccff_head(head_v[1]), .ccff_tail(tail_v[1]), .ccff_en(en_v[1]),
        .isol_n(isol_v[1]), .busy(busy_v[1]), .done(done_v[1]), .error(error_v[1]));

    // External chains: shift toward the tail only on enabled edges.
    always @(posedge prog_clk) if (en_v[0]) chain0 <= {chain0[14:0], head_v[0]};
    always @(posedge prog_clk) if (en_v[1]) chain1 <= {chain1[10:0], head_v[1]};
    assign tail_v[0] = chain0[15] ^ flip_v[0];
    assign tail_v[1] = chain1[11] ^ flip_v[1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic b);
        return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
    endfunction

    function automatic logic [15:0] chain_of(input int s);
        return (s != 0) ? {4'b0, chain1} : chain0;
    endfunction

    task automatic check_idle_outputs(input int s, input string tag);
        chk({tag, "_rdy"},  32'(cfg_ready_v[s]), 0);
        chk({tag, "_en"},   32'(en_v[s]), 0);
        chk({tag, "_head"}, 32'(head_v[s]), 0);
        chk({tag, "_isol"}, 32'(isol_v[s]), 0);
        chk({tag, "_busy"}, 32'(busy_v[s]), 0);
        chk({tag, "_done"}, 32'(done_v[s]), 0);
        chk({tag, "_err"},  32'(error_v[s]), 0);
    endtask

    // One load on instance s. flip_at: verify cycle whose tail bit is inverted (-1 none);
    // abort_at: LOAD cycle at which reset is pulsed (-1 none).
    task automatic run_load(input int s, input int flip_at, input bit spur, input int abort_at);
        int         len, nw, used, tot, c, idx, hold, acc, en_cnt;
        bit         fin, gap;
        logic       bits[$];
        logic [7:0] ci, co;
        logic [15:0] exp_chain;
        bit         err_exp;
        len = (s != 0) ? 12 : 16;
        nw  = (len + 7) / 8;
        tot = len + 1;
        bits = {};
        for (int i = 0; i < nw; i++) begin
            used = (len - 8 * i < 8) ? len - 8 * i : 8;
            tot += 1 + used + gq[i];
            for (int b = 7; b >= 8 - used; b--) bits.push_back(wq[i][b]);
        end
        ci = '0; co = '0; exp_chain = '0;
        for (int k = 0; k < len; k++) begin
            ci = crc8(ci, bits[k]);
            co = crc8(co, bits[k] ^ (k == flip_at));
            exp_chain = {exp_chain[14:0], bits[k] ^ (k == flip_at)};
        end
        err_exp = (ci != co);

        @(negedge prog_clk);
        start_v[s] = 1'b1;
        @(negedge prog_clk);
        start_v[s] = 1'b0;
        chk("entry_busy", 32'(busy_v[s]), 1);
        chk("entry_isol", 32'(isol_v[s]), 0);
        chk("entry_done", 32'(done_v[s]), 0);
        chk("entry_err",  32'(error_v[s]), 0);

        c = 0; idx = 0; hold = gq[0]; acc = 0; en_cnt = 0; fin = 0;
        while (!fin && c < tot + 20) begin
            if (c == abort_at) begin
                pReset_v[s] = 1'b1;
                #1;
                check_idle_outputs(s, "abort");
                @(negedge prog_clk);
                pReset_v[s] = 1'b0;
                cfg_valid_v[s] = 1'b0;
                return;
            end
            if (done_v[s] || error_v[s]) begin
                fin = 1;
            end else begin
                gap = cfg_ready_v[s] && (hold > 0);
                if (gap) hold--;
                cfg_valid_v[s] = (hold == 0) && !gap && (idx <= nw);
                cfg_data_v[s]  = wq[(idx <= 3) ? idx : 3];
                flip_v[s] = (flip_at >= 0) && (en_cnt >= len) && (en_cnt - len == flip_at);
                start_v[s] = spur && (c == 4 || c == tot - 4);
                #1;
                if (gap) chk("gap_en", 32'(en_v[s]), 0);
                if (en_v[s]) begin
                    if (en_cnt < len) chk("head_bit", 32'(head_v[s]), 32'(bits[en_cnt]));
                    en_cnt++;
                end
                if (cfg_ready_v[s] && cfg_valid_v[s]) begin
                    acc++;
                    idx++;
                    hold = (idx < 4) ? gq[idx] : 0;
                end
                @(negedge prog_clk);
                c++;
            end
        end
        start_v[s] = 1'b0;
        cfg_valid_v[s] = 1'b0;
        flip_v[s] = 1'b0;
        chk("finished",  32'(fin), 1);
        chk("cycles",    32'(c), 32'(tot));
        chk("words_acc", 32'(acc), 32'(nw));
        chk("en_cycles", 32'(en_cnt), 32'(2 * len));
        chk("done",      32'(done_v[s]), 32'(!err_exp));
        chk("error",     32'(error_v[s]), 32'(err_exp));
        chk("isol_n",    32'(isol_v[s]), 32'(!err_exp));
        chk("busy_end",  32'(busy_v[s]), 0);
        chk("chain",     32'(chain_of(s)), 32'(exp_chain));
    endtask

    initial begin
        int s, len, fa;
        bit sp;
        #1;
        check_idle_outputs(0, "rst0");
        check_idle_outputs(1, "rst1");
        repeat (3) @(negedge prog_clk);
        pReset_v = 2'b00;
        @(negedge prog_clk);
        check_idle_outputs(0, "post_rst");

        // Basic 16-bit load, A5 then 3C.
        wq = '{8'hA5, 8'h3C, 8'h00, 8'h00};
        gq = '{0, 0, 0, 0};
        run_load(0, -1, 0, -1);
        chk("chain_a53c", 32'(chain0), 32'h0000A53C);

        // Same load with a 5-cycle source stall between words.
        gq = '{0, 5, 0, 0};
        run_load(0, -1, 0, -1);

        // 12-bit chain: only the top nibble of the second word is used.
        wq = '{8'hFF, 8'hA7, 8'h55, 8'h00};
        gq = '{0, 0, 0, 0};
        run_load(1, -1, 0, -1);
        chk("chain_ffa", 32'(chain1), 32'h00000FFA);

        // Corrupted tail during verify, then a clean reload.
        wq = '{8'hA5, 8'h3C, 8'h00, 8'h00};
        run_load(0, 3, 0, -1);
        run_load(0, -1, 0, -1);

        // Reset mid-load, then full load; then spurious starts while busy.
        run_load(0, -1, 0, 10);
        run_load(0, -1, 0, -1);
        run_load(0, -1, 1, -1);

        for (int r = 0; r < 16; r++) begin
            s   = int'($urandom_range(0, 1));
            len = (s != 0) ? 12 : 16;
            for (int i = 0; i < 4; i++) begin
                wq[i] = 8'($urandom);
                gq[i] = int'($urandom_range(0, 3));
            end
            fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            sp = 1'($urandom_range(0, 1));
            run_load(s, fa, sp, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
